intr_timer_ctrl: RTL

- Memory-mapped interrupt source block directly upstream of `core`.
- Generates the `timer_intr` and `ext_intr` level inputs that `core` consumes.
- Contains:
  - a 64-bit machine timer (`mtime`/`mtimecmp`) with a programmable prescaler;
  - a latched, claimable external interrupt line.
- `core` reaches it through a simple single-cycle request/ready register bus.

---
 rtl/intr_pkg.sv | 21 ++
 rtl/intr_timer_ctrl_if.sv | 14 +
 rtl/sync_edge.sv | 26 ++
 rtl/intr_timer_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/intr_pkg.sv
// Shared register map, reset constants and types for the interrupt/timer block.
package intr_pkg;

    localparam int unsigned REG_OFF_W = 5;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned TIME_W    = 64;

    typedef logic [TIME_W-1:0] mtime_t;

    localparam logic [REG_OFF_W-1:0] MTIME_LO    = 5'h00;
    localparam logic [REG_OFF_W-1:0] MTIME_HI    = 5'h04;
    localparam logic [REG_OFF_W-1:0] MTIMECMP_LO = 5'h08;
    localparam logic [REG_OFF_W-1:0] MTIMECMP_HI = 5'h0C;
    localparam logic [REG_OFF_W-1:0] EXT_PENDING = 5'h10;
    localparam logic [REG_OFF_W-1:0] EXT_ENABLE  = 5'h14;
    localparam logic [REG_OFF_W-1:0] EXT_CLAIM   = 5'h18;
    localparam logic [REG_OFF_W-1:0] PRESCALE    = 5'h1C;

    localparam mtime_t MTIMECMP_RST = '1;

endpackage

// File: rtl/intr_timer_ctrl_if.sv
// Single-cycle request/ready register bus between core (master) and the block.
interface intr_timer_ctrl_if #(
    parameter int unsigned ADDR_W = 5
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ready;

    modport master (output req, we, addr, wdata, input rdata, ready);
    modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, plus a rising-edge pulse.
module sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_c_o
);

    logic [STAGES-1:0] sync_q;
    logic              last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            last_q <= sync_q[STAGES-1];
        end
    end

    assign rise_c_o = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/intr_timer_ctrl.sv
// Machine timer (mtime/mtimecmp with prescaler) and claimable external interrupt,
// exposed on a single-cycle register bus.
module intr_timer_ctrl
    import intr_pkg::*;
#(
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned PRESC_W     = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    intr_timer_ctrl_if.slave   bus,
    input  logic               ext_src,
    output logic               timer_intr,
    output logic               ext_intr
);

    logic [ADDR_W-1:0]    addr_w;
    logic [REG_OFF_W-1:0] reg_off;
    logic                 unused_addr;
    logic                 wr_c, rd_c, tick_c, ext_rise_c;

    mtime_t               mtime_q, mtime_d;
    mtime_t               mtimecmp_q, mtimecmp_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [PRESC_W-1:0]   presc_cnt_q, presc_cnt_d;
    logic                 pend_q, pend_d;
    logic                 en_q, en_d;
    logic                 ready_q, ready_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 timer_intr_q, timer_intr_d;
    logic                 ext_intr_q, ext_intr_d;

    assign addr_w      = bus.addr;
    assign reg_off     = {addr_w[4:2], 2'b00};
    assign unused_addr = ^addr_w[1:0];

    assign wr_c   = bus.req & bus.we;
    assign rd_c   = bus.req & ~bus.we;
    assign tick_c = (presc_cnt_q == presc_q);

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_edge (
        .clk      (clk),
        .rst      (rst),
        .d_i      (ext_src),
        .rise_c_o (ext_rise_c)
    );

    // Next-state for registers, bus response and interrupts
    always_comb begin
        mtime_d     = mtime_q;
        mtimecmp_d  = mtimecmp_q;
        presc_d     = presc_q;
        presc_cnt_d = tick_c ? '0 : presc_cnt_q + PRESC_W'(1);
        pend_d      = pend_q;
        en_d        = en_q;
        ready_d     = bus.req;
        rdata_d     = '0;

        if (tick_c) begin
            mtime_d = mtime_q + TIME_W'(1);
        end

        if (rd_c) begin
            case (reg_off)
                MTIME_LO:    rdata_d = mtime_q[31:0];
                MTIME_HI:    rdata_d = mtime_q[63:32];
                MTIMECMP_LO: rdata_d = mtimecmp_q[31:0];
                MTIMECMP_HI: rdata_d = mtimecmp_q[63:32];
                EXT_PENDING: rdata_d = DATA_W'(pend_q);
                EXT_ENABLE:  rdata_d = DATA_W'(en_q);
                EXT_CLAIM:   rdata_d = DATA_W'(pend_q);
                PRESCALE:    rdata_d = DATA_W'(presc_q);
                default:     rdata_d = '0;
            endcase
            if (reg_off == EXT_CLAIM) begin
                pend_d = 1'b0;
            end
        end

        // A write to one mtime half suppresses the increment of both halves
        if (wr_c) begin
            case (reg_off)
                MTIME_LO:    mtime_d = {mtime_q[63:32], bus.wdata};
                MTIME_HI:    mtime_d = {bus.wdata, mtime_q[31:0]};
                MTIMECMP_LO: mtimecmp_d[31:0]  = bus.wdata;
                MTIMECMP_HI: mtimecmp_d[63:32] = bus.wdata;
                EXT_ENABLE:  en_d = bus.wdata[0];
                PRESCALE: begin
                    presc_d     = bus.wdata[PRESC_W-1:0];
                    presc_cnt_d = '0;
                end
                default: ;
            endcase
        end

        if (ext_rise_c) begin
            pend_d = 1'b1;
        end

        timer_intr_d = (mtime_d >= mtimecmp_d);
        ext_intr_d   = pend_q & en_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_q      <= '0;
            mtimecmp_q   <= MTIMECMP_RST;
            presc_q      <= '0;
            presc_cnt_q  <= '0;
            pend_q       <= 1'b0;
            en_q         <= 1'b0;
            ready_q      <= 1'b0;
            rdata_q      <= '0;
            timer_intr_q <= 1'b0;
            ext_intr_q   <= 1'b0;
        end else begin
            mtime_q      <= mtime_d;
            mtimecmp_q   <= mtimecmp_d;
            presc_q      <= presc_d;
            presc_cnt_q  <= presc_cnt_d;
            pend_q       <= pend_d;
            en_q         <= en_d;
            ready_q      <= ready_d;
            rdata_q      <= rdata_d;
            timer_intr_q <= timer_intr_d;
            ext_intr_q   <= ext_intr_d;
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.ready  = ready_q;
    assign timer_intr = timer_intr_q;
    assign ext_intr   = ext_intr_q;

endmodule
